// File: rtl/debounce_filter.sv
// debounce_filter: synchronizes a raw input and accepts a level change only
// after it has held for STABLE_CYCLES+1 synchronized samples.
//   clk      : single clock, rising edge
//   rst      : synchronous active-high reset
//   din      : raw asynchronous input
//   clr_cnt  : synchronous clear of edge_cnt
//   dout     : debounced level (registered)
//   rise     : one-cycle pulse on an accepted 0->1 transition (registered)
//   fall     : one-cycle pulse on an accepted 1->0 transition (registered)
//   busy     : a transition is being qualified (decoded from state)
//   edge_cnt : wrapping count of accepted rising edges
module debounce_filter #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             clr_cnt,
  output logic             dout,
  output logic             rise,
  output logic             fall,
  output logic             busy,
  output logic [CNT_W-1:0] edge_cnt
);

  localparam int unsigned QCNT_W = 8;
  localparam logic [QCNT_W-1:0] QMAX = QCNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOW    = 2'd0,
    CHK_HI = 2'd1,
    HIGH   = 2'd2,
    CHK_LO = 2'd3
  } state_t;

  logic              s1;
  logic              s2;
  state_t            state;
  state_t            state_nxt;
  logic [QCNT_W-1:0] qcnt;
  logic [QCNT_W-1:0] qcnt_nxt;
  logic              dout_nxt;
  logic              rise_nxt;
  logic              fall_nxt;
  logic [CNT_W-1:0]  edge_cnt_nxt;

  // State and output registers; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      state    <= LOW;
      qcnt     <= '0;
      dout     <= 1'b0;
      rise     <= 1'b0;
      fall     <= 1'b0;
      edge_cnt <= '0;
    end else begin
      s1       <= din;
      s2       <= s1;
      state    <= state_nxt;
      qcnt     <= qcnt_nxt;
      dout     <= dout_nxt;
      rise     <= rise_nxt;
      fall     <= fall_nxt;
      edge_cnt <= edge_cnt_nxt;
    end
  end

  // Next-state, qualify counter and next output values.
  always_comb begin
    state_nxt = state;
    qcnt_nxt  = qcnt;
    dout_nxt  = dout;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      LOW: begin
        if (s2) begin
          state_nxt = CHK_HI;
          qcnt_nxt  = '0;
        end
      end
      CHK_HI: begin
        if (!s2) begin
          state_nxt = LOW;
          qcnt_nxt  = '0;
        end else if (qcnt == QMAX) begin
          state_nxt = HIGH;
          qcnt_nxt  = '0;
          dout_nxt  = 1'b1;
          rise_nxt  = 1'b1;
        end else begin
          qcnt_nxt = qcnt + QCNT_W'(1);
        end
      end
      HIGH: begin
        if (!s2) begin
          state_nxt = CHK_LO;
          qcnt_nxt  = '0;
        end
      end
      CHK_LO: begin
        if (s2) begin
          state_nxt = HIGH;
          qcnt_nxt  = '0;
        end else if (qcnt == QMAX) begin
          state_nxt = LOW;
          qcnt_nxt  = '0;
          dout_nxt  = 1'b0;
          fall_nxt  = 1'b1;
        end else begin
          qcnt_nxt = qcnt + QCNT_W'(1);
        end
      end
      default: begin
        state_nxt = LOW;
        qcnt_nxt  = '0;
        dout_nxt  = 1'b0;
      end
    endcase
  end

  // Clear wins over the old value, but a same-edge accepted rise still counts.
  always_comb begin
    edge_cnt_nxt = clr_cnt ? '0 : edge_cnt;
    if (rise_nxt) begin
      edge_cnt_nxt = edge_cnt_nxt + CNT_W'(1);
    end
  end

  assign busy = (state == CHK_HI) || (state == CHK_LO);

endmodule

// File: tb/tb_debounce_filter.sv
// Bench for debounce_filter: a behavioural model predicts every cycle's
// outputs into a scoreboard queue, and directed steps add scenario checks.
// A downstream d_ff (q) is modelled here and checked to follow dout.
module tb_debounce_filter;

  localparam int unsigned STABLE_CYCLES = 4;
  localparam int unsigned CNT_W         = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             din;
  logic             clr_cnt;
  logic             dout;
  logic             rise;
  logic             fall;
  logic             busy;
  logic [CNT_W-1:0] edge_cnt;
  logic             q;

  debounce_filter #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .CNT_W        (CNT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .din     (din),
    .clr_cnt (clr_cnt),
    .dout    (dout),
    .rise    (rise),
    .fall    (fall),
    .busy    (busy),
    .edge_cnt(edge_cnt)
  );

  always #5 clk = ~clk;

  // Downstream d_ff on the same clock and reset.
  always_ff @(posedge clk) begin
    q <= rst ? 1'b0 : dout;
  end

  typedef struct packed {
    logic             dout;
    logic             rise;
    logic             fall;
    logic             busy;
    logic [CNT_W-1:0] cnt;
    logic             q;
  } exp_t;

  exp_t sb[$];

  // Model: level plus a run length of consecutive synchronized samples that
  // disagree with it; the (STABLE_CYCLES+1)-th disagreeing sample flips it.
  logic             m_s1;
  logic             m_s2;
  logic             m_level;
  int unsigned      m_run;
  logic [CNT_W-1:0] m_cnt;

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  int cyc    = 0;
  int rise_seen = 0;
  int fall_seen = 0;
  int busy_edges = 0;
  int last_rise_cyc = 0;
  int c0 = 0;
  logic prev_busy = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic step(input logic d, input logic c, input logic r);
    exp_t e;
    exp_t got;
    logic old_s2;
    din     = d;
    clr_cnt = c;
    rst     = r;
    @(posedge clk);
    e = '0;
    if (r) begin
      m_s1    = 1'b0;
      m_s2    = 1'b0;
      m_level = 1'b0;
      m_run   = 0;
      m_cnt   = '0;
      e.q     = 1'b0;
    end else begin
      e.q    = m_level;
      old_s2 = m_s2;
      m_s2   = m_s1;
      m_s1   = d;
      if (old_s2 !== m_level) begin
        m_run++;
        if (m_run == STABLE_CYCLES + 1) begin
          m_level = old_s2;
          m_run   = 0;
          e.rise  = old_s2;
          e.fall  = ~old_s2;
        end
      end else begin
        m_run = 0;
      end
      if (c) m_cnt = '0;
      if (e.rise) m_cnt = m_cnt + CNT_W'(1);
    end
    e.dout = m_level;
    e.busy = (m_run != 0);
    e.cnt  = m_cnt;
    sb.push_back(e);
    @(negedge clk);
    cyc++;
    got = sb.pop_front();
    check("dout", 32'(dout), 32'(got.dout));
    check("rise", 32'(rise), 32'(got.rise));
    check("fall", 32'(fall), 32'(got.fall));
    check("busy", 32'(busy), 32'(got.busy));
    check("edge_cnt", 32'(edge_cnt), 32'(got.cnt));
    check("dff_q", 32'(q), 32'(got.q));
    if (rise === 1'b1) begin
      rise_seen++;
      last_rise_cyc = cyc;
    end
    if (fall === 1'b1) fall_seen++;
    if (busy !== prev_busy) busy_edges++;
    prev_busy = busy;
  endtask

  task automatic pulse(input int n_hi, input int n_lo);
    for (int i = 0; i < n_hi; i++) step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < n_lo; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset state
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cnt", 32'(edge_cnt), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);

    // Clean rise: pulse after E0+6
    rise_seen = 0;
    c0 = cyc + 1;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
    check("clean_rise_count", 32'(rise_seen), 32'd1);
    check("clean_rise_latency", 32'(last_rise_cyc - c0), 32'd6);
    check("clean_rise_dout", 32'(dout), 32'd1);
    check("clean_rise_cnt", 32'(edge_cnt), 32'd1);

    // Clean fall
    fall_seen = 0;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);
    check("clean_fall_count", 32'(fall_seen), 32'd1);
    check("clean_fall_dout", 32'(dout), 32'd0);

    // 4-cycle glitch rejected
    step(1'b0, 1'b1, 1'b0);
    rise_seen = 0;
    pulse(4, 12);
    check("glitch4_rise", 32'(rise_seen), 32'd0);
    check("glitch4_dout", 32'(dout), 32'd0);
    check("glitch4_cnt", 32'(edge_cnt), 32'd0);

    // 5-cycle pulse accepted, then falls
    rise_seen = 0;
    fall_seen = 0;
    pulse(5, 12);
    check("pulse5_rise", 32'(rise_seen), 32'd1);
    check("pulse5_fall", 32'(fall_seen), 32'd1);
    check("pulse5_cnt", 32'(edge_cnt), 32'd1);

    // Bounce: 20 toggles then held high
    rise_seen = 0;
    busy_edges = 0;
    for (int i = 0; i < 20; i++) step((i % 2) == 0, 1'b0, 1'b0);
    check("bounce_no_rise", 32'(rise_seen), 32'd0);
    check("bounce_busy_toggles", 32'(busy_edges > 4), 32'd1);
    c0 = cyc + 1;
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0);
    check("bounce_rise_count", 32'(rise_seen), 32'd1);
    check("bounce_rise_latency", 32'(last_rise_cyc - c0), 32'd6);
    check("bounce_cnt", 32'(edge_cnt), 32'd2);

    // Clear on the same edge as an accepted rise
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0);
    for (int k = 0; k <= 6; k++) step(1'b1, k == 6, 1'b0);
    check("clr_rise_pulse", 32'(rise), 32'd1);
    check("clr_rise_cnt", 32'(edge_cnt), 32'd1);

    // Reset while qualifying a fall from dout=1
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
    check("chk_lo_busy", 32'(busy), 32'd1);
    check("chk_lo_dout", 32'(dout), 32'd1);
    step(1'b1, 1'b1, 1'b1);
    check("midrst_dout", 32'(dout), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_fall", 32'(fall), 32'd0);
    check("midrst_cnt", 32'(edge_cnt), 32'd0);

    // Rise qualified after reset release with din held high
    rise_seen = 0;
    c0 = cyc + 1;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
    check("postrst_rise_latency", 32'(last_rise_cyc - c0), 32'd6);
    check("postrst_cnt", 32'(edge_cnt), 32'd1);

    // Counter wrap after 256 accepted rises
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 255; n++) pulse(8, 10);
    check("wrap_255", 32'(edge_cnt), 32'd255);
    pulse(8, 10);
    check("wrap_0", 32'(edge_cnt), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
